instr_prefetch_queue: RTL and testbench

- Sits between the byte-wide instruction ROM (10-bit address, 8-bit data, registered address) and the instruction receiver.
- Streams bytes from the ROM starting at a loaded PC and buffers them in a circular byte queue.
- Presents a 4-byte little-endian window plus its PC. The receiver consumes 1-4 bytes per cycle, so it no longer issues ROM reads itself.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/byte_queue.sv | 72 +++++++
 rtl/instr_prefetch_queue.sv | 111 +++++++++++
 tb/tb_instr_prefetch_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction prefetch queue.
//   WINDOW_BYTES   : width of the presented instruction window in bytes
//   DEFAULT_ROM_AW : default instruction ROM address width
//   DEFAULT_DEPTH  : default queue capacity in bytes
//   len_t          : consume length (1-4 meaningful, 0 = no-op, 5-7 clamp to 4)
package fetch_pkg;

    localparam int unsigned WINDOW_BYTES   = 4;
    localparam int unsigned DEFAULT_ROM_AW = 10;
    localparam int unsigned DEFAULT_DEPTH  = 8;

    typedef logic [2:0] len_t;

endpackage

// File: rtl/byte_queue.sv
// Circular byte queue with single-byte push, 0-4 byte pop and a 4-byte peek window.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop all contents (head jumps to tail); wins over push/pop
//   push, push_data : append one byte at the tail
//   pop_len         : bytes retired from the head this cycle (caller keeps it <= count)
//   peek            : {q[3],q[2],q[1],q[0]}, bytes beyond count read as 0
//   count           : current occupancy
module byte_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [7:0]                  push_data,
    input  len_t                        pop_len,
    output logic [8*WINDOW_BYTES-1:0]   peek,
    output logic [CW-1:0]               count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q + AW'(pop_len);
        tail_d  = tail_q + AW'(push);
        count_d = count_q + CW'(push) - CW'(pop_len);
        if (flush) begin
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: unoccupied slots are masked in the peek window.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_q[tail_q] <= push_data;
        end
    end

    always_comb begin
        peek = '0;
        for (int i = 0; i < int'(WINDOW_BYTES); i++) begin
            if (CW'(i) < count_q) begin
                peek[8*i +: 8] = mem_q[head_q + AW'(i)];
            end
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: streams bytes from a registered-address byte ROM starting
// at a loaded PC and presents a 4-byte little-endian window with its PC.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   en                   : fetch enable (gates new ROM reads only)
//   pc_in, pc_load       : redirect target and strobe (flush + restart fetch)
//   rom_addr, rom_data   : ROM read port; data valid the cycle after the address
//   instr_word, instr_pc : window {q[3],q[2],q[1],q[0]} and byte address of q[0]
//   instr_valid          : window holds at least 4 bytes
//   consume, consume_len : receiver retires 1-4 bytes (ignored while not valid)
//   byte_count           : queue occupancy (debug)
module instr_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ROM_AW = DEFAULT_ROM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [31:0]       pc_in,
    input  logic              pc_load,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [31:0]       instr_word,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              consume,
    input  len_t              consume_len,
    output logic [3:0]        byte_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    logic [31:0]   fetch_ptr_q, fetch_ptr_d;
    logic [31:0]   instr_pc_q, instr_pc_d;
    logic          epoch_q, epoch_d;
    logic          inflight_q, inflight_d;
    logic          inflight_epoch_q, inflight_epoch_d;

    logic [CW-1:0] count;
    logic [OW-1:0] occupancy;
    logic          issue;
    logic          capture;
    len_t          pop_len;

    // Space is reserved at issue time against pre-consume occupancy plus the pending
    // read, so a capture can never overflow the queue.
    assign occupancy   = {1'b0, count} + OW'(inflight_q);
    assign issue       = en && !pc_load && (occupancy < OW'(DEPTH));
    // A read issued before a redirect carries the old epoch and is dropped.
    assign capture     = inflight_q && (inflight_epoch_q == epoch_q) && !pc_load;
    assign instr_valid = (count >= CW'(WINDOW_BYTES));

    always_comb begin
        pop_len = '0;
        if (consume && instr_valid && !pc_load) begin
            pop_len = (consume_len > len_t'(WINDOW_BYTES)) ? len_t'(WINDOW_BYTES)
                                                           : consume_len;
        end
    end

    always_comb begin
        fetch_ptr_d      = fetch_ptr_q + 32'(issue);
        instr_pc_d       = instr_pc_q + 32'(pop_len);
        epoch_d          = epoch_q;
        inflight_d       = issue;
        inflight_epoch_d = epoch_q;
        if (pc_load) begin
            fetch_ptr_d = pc_in;
            instr_pc_d  = pc_in;
            epoch_d     = ~epoch_q;
            inflight_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_ptr_q      <= '0;
            instr_pc_q       <= '0;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
        end else begin
            fetch_ptr_q      <= fetch_ptr_d;
            instr_pc_q       <= instr_pc_d;
            epoch_q          <= epoch_d;
            inflight_q       <= inflight_d;
            inflight_epoch_q <= inflight_epoch_d;
        end
    end

    byte_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (pc_load),
        .push      (capture),
        .push_data (rom_data),
        .pop_len   (pop_len),
        .peek      (instr_word),
        .count     (count)
    );

    assign rom_addr   = fetch_ptr_q[ROM_AW-1:0];
    assign instr_pc   = instr_pc_q;
    assign byte_count = 4'(count);

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: directed vector table, hand sequences for
// redirect/reset corner cases, and randomized traffic against a byte-queue reference model.
module tb_instr_prefetch_queue;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, en, pc_load, consume;
    logic [31:0] pc_in;
    len_t        consume_len;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [31:0] instr_word, instr_pc;
    logic        instr_valid;
    logic [3:0]  byte_count;

    instr_prefetch_queue #(
        .DEPTH  (DEPTH),
        .ROM_AW (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pc_in       (pc_in),
        .pc_load     (pc_load),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr_word  (instr_word),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .consume     (consume),
        .consume_len (consume_len),
        .byte_count  (byte_count)
    );

    always #5 clk = ~clk;

    // Registered-address ROM: byte[a] = a[7:0] ^ 8'h5A.
    always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'h5A;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: byte list, one pending read, fetch pointer and window PC.
    logic [7:0]  mq[$];
    logic [31:0] m_fptr = 0;
    logic [31:0] m_pc = 0;
    bit          m_pend = 0;
    logic [9:0]  m_pend_addr = 0;

    typedef struct {
        int unsigned rst, en, ld, pcin, cons, len;
        int unsigned ev, ew, epc, ecnt, erom;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(int unsigned r, int unsigned e, int unsigned l,
                                int unsigned pci, int unsigned c, int unsigned ln,
                                int unsigned ev, int unsigned ew, int unsigned epc,
                                int unsigned ec, int unsigned er);
        vec_t v;
        v.rst = r; v.en = e; v.ld = l; v.pcin = pci; v.cons = c; v.len = ln;
        v.ev = ev; v.ew = ew; v.epc = epc; v.ecnt = ec; v.erom = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < mq.size()) w[8*i +: 8] = mq[i];
        end
        return w;
    endfunction

    task automatic model_update();
        int old;
        int n;
        bit iss;
        if (rst) begin
            mq.delete(); m_fptr = 0; m_pc = 0; m_pend = 0;
        end else if (pc_load) begin
            mq.delete(); m_fptr = pc_in; m_pc = pc_in; m_pend = 0;
        end else begin
            old = mq.size();
            iss = en && ((old + int'(m_pend)) < int'(DEPTH));
            n = (consume_len > 3'd4) ? 4 : int'(consume_len);
            if (consume && old >= 4) begin
                for (int i = 0; i < n; i++) void'(mq.pop_front());
                m_pc = m_pc + 32'(n);
            end
            if (m_pend) mq.push_back(m_pend_addr[7:0] ^ 8'h5A);
            m_pend = iss;
            m_pend_addr = m_fptr[9:0];
            if (iss) m_fptr = m_fptr + 1;
        end
    endtask

    task automatic compare_model();
        check("m_valid", 32'(instr_valid), 32'(mq.size() >= 4));
        check("m_word", instr_word, model_word());
        check("m_pc", instr_pc, m_pc);
        check("m_count", 32'(byte_count), 32'(mq.size()));
        check("m_rom_addr", 32'(rom_addr), 32'(m_fptr[9:0]));
        check("valid_vs_count", 32'(instr_valid && (byte_count < 4'd4)), 32'd0);
        check("count_le_depth", 32'(byte_count > 4'(DEPTH)), 32'd0);
    endtask

    // Drive one cycle of inputs (at the falling edge), step the model, sample at the next
    // falling edge.
    task automatic step(input logic a_rst, input logic a_en, input logic a_ld,
                        input logic [31:0] a_pc, input logic a_cons, input len_t a_len);
        rst = a_rst; en = a_en; pc_load = a_ld; pc_in = a_pc;
        consume = a_cons; consume_len = a_len;
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; pc_load = 1'b0; pc_in = '0; consume = 1'b0;
        consume_len = '0;

        //          rst en ld pc_in cons len | valid word         pc    cnt rom
        tbl[0]  = mk(1, 0, 0, 0,    0, 0,     0, 32'h0,        0,    0, 0);
        tbl[1]  = mk(0, 1, 1, 'h10, 0, 0,     0, 32'h0,        'h10, 0, 'h10);
        tbl[2]  = mk(0, 1, 0, 0,    0, 0,     0, 32'h0,        'h10, 0, 'h11);
        tbl[3]  = mk(0, 1, 0, 0,    0, 0,     0, 32'h4A,       'h10, 1, 'h12);
        tbl[4]  = mk(0, 1, 0, 0,    1, 2,     0, 32'h4B4A,     'h10, 2, 'h13);
        tbl[5]  = mk(0, 1, 0, 0,    0, 0,     0, 32'h484B4A,   'h10, 3, 'h14);
        tbl[6]  = mk(0, 1, 0, 0,    0, 0,     1, 32'h49484B4A, 'h10, 4, 'h15);
        tbl[7]  = mk(0, 1, 0, 0,    0, 0,     1, 32'h49484B4A, 'h10, 5, 'h16);
        tbl[8]  = mk(0, 1, 0, 0,    0, 0,     1, 32'h49484B4A, 'h10, 6, 'h17);
        tbl[9]  = mk(0, 1, 0, 0,    0, 0,     1, 32'h49484B4A, 'h10, 7, 'h18);
        tbl[10] = mk(0, 1, 0, 0,    0, 0,     1, 32'h49484B4A, 'h10, 8, 'h18);
        tbl[11] = mk(0, 1, 0, 0,    1, 0,     1, 32'h49484B4A, 'h10, 8, 'h18);
        tbl[12] = mk(0, 1, 0, 0,    1, 7,     1, 32'h4D4C4F4E, 'h14, 4, 'h18);
        tbl[13] = mk(0, 1, 0, 0,    0, 0,     1, 32'h4D4C4F4E, 'h14, 4, 'h19);
        tbl[14] = mk(0, 1, 0, 0,    0, 0,     1, 32'h4D4C4F4E, 'h14, 5, 'h1A);

        @(negedge clk);

        // Startup latency, invalid/zero/clamped consume, full-queue fetch stall and resume.
        for (int i = 0; i < 15; i++) begin
            step(1'(tbl[i].rst), 1'(tbl[i].en), 1'(tbl[i].ld), tbl[i].pcin,
                 1'(tbl[i].cons), len_t'(tbl[i].len));
            check($sformatf("tv%0d_valid", i), 32'(instr_valid), tbl[i].ev);
            check($sformatf("tv%0d_word", i), instr_word, tbl[i].ew);
            check($sformatf("tv%0d_pc", i), instr_pc, tbl[i].epc);
            check($sformatf("tv%0d_count", i), 32'(byte_count), tbl[i].ecnt);
            check($sformatf("tv%0d_rom", i), 32'(rom_addr), tbl[i].erom);
        end

        // Redirect to 0x3FE with a read in flight; window wraps across 0x3FF -> 0x000.
        step(1'b0, 1'b1, 1'b1, 32'h3FE, 1'b0, 3'd0);
        check("s4_load_count", 32'(byte_count), 32'd0);
        check("s4_load_pc", instr_pc, 32'h3FE);
        check("s4_load_rom", 32'(rom_addr), 32'h3FE);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0);
        check("s4_stale_dropped", 32'(byte_count), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0);
        check("s4_valid", 32'(instr_valid), 32'd1);
        check("s4_word", instr_word, 32'h5B5AA5A4);
        check("s4_pc", instr_pc, 32'h3FE);

        // Redirect together with a valid consume: redirect wins.
        step(1'b0, 1'b1, 1'b1, 32'h123, 1'b1, 3'd3);
        check("s5_count", 32'(byte_count), 32'd0);
        check("s5_pc", instr_pc, 32'h123);
        check("s5_valid", 32'(instr_valid), 32'd0);

        // Reset mid-stream at count=6 with a read in flight.
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 3'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0);
        check("s6_count6", 32'(byte_count), 32'd6);
        step(1'b1, 1'b1, 1'b1, 32'h55, 1'b1, 3'd2);
        check("s6_word", instr_word, 32'h0);
        check("s6_pc", instr_pc, 32'h0);
        check("s6_valid", 32'(instr_valid), 32'd0);
        check("s6_count", 32'(byte_count), 32'd0);
        check("s6_rom", 32'(rom_addr), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0);
        check("s6_late_byte", 32'(byte_count), 32'd0);

        // Steady consume of 2 bytes per valid cycle from 0x10.
        step(1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 3'd0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd2);
        check("s2_pc_even", 32'(instr_pc[0]), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_en, r_ld, r_cons;
            logic [31:0] r_pc;
            len_t        r_len;
            r_rst  = ($urandom_range(0, 199) == 0);
            r_ld   = ($urandom_range(0, 29) == 0);
            r_pc   = ($urandom_range(0, 3) == 0) ? 32'h3FC + 32'($urandom_range(0, 3))
                                                 : $urandom();
            r_en   = ($urandom_range(0, 9) < 8);
            r_cons = ($urandom_range(0, 9) < 6);
            r_len  = 3'($urandom_range(0, 7));
            step(r_rst, r_en, r_ld, r_pc, r_cons, r_len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
